// File: rtl/mmio_lsu.sv
// mmio_lsu: load/store initiator for the peripheral MMIO bus.
// Accepts one CPU load/store at a time and checks its alignment. It then
// drives the fixed-latency responder handshake and returns extended load
// data plus a completion cause.
// Optional feature: define MMIO_FAULT_EN to gate strobes on bus_addr_valid
// and report unmapped accesses as an access fault (cause 2).

module mmio_lsu #(
    parameter int TIMEOUT_UNUSED = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic [1:0]  resp_cause,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_wstrb,
    output logic        bus_read_en,
    input  logic [31:0] bus_rdata,
    input  logic        bus_addr_valid
);

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ,
        CAPTURE,
        RESP
    } state_t;

    localparam logic [1:0] CAUSE_OK       = 2'd0;
    localparam logic [1:0] CAUSE_MISALIGN = 2'd1;
    localparam logic [1:0] CAUSE_ACCESS   = 2'd2;
    localparam logic [1:0] CAUSE_SIZE     = 2'd3;

    state_t      state_q, state_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  lane_q, lane_d;
    logic [1:0]  size_q, size_d;
    logic [1:0]  cause_q, cause_d;
    logic        unsigned_q, unsigned_d;

    logic        req_misaligned;
    logic [3:0]  strb_mask;
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic [31:0] load_ext;

    // The timeout parameter is reserved; the responder is fixed-latency.
    logic [31:0] timeout_unused;
    assign timeout_unused = TIMEOUT_UNUSED;

`ifdef MMIO_FAULT_EN
    localparam logic FAULT_EN = 1'b1;
`else
    localparam logic FAULT_EN = 1'b0;
    logic addr_valid_unused;
    assign addr_valid_unused = bus_addr_valid;
`endif

    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;

    // Decode alignment, strobe lanes and load lane extraction/extension.
    always_comb begin
        req_misaligned = ((req_size == 2'd1) && req_addr[0]) ||
                         ((req_size == 2'd2) && (req_addr[1:0] != 2'b00));

        case (size_q)
            2'd0:    strb_mask = 4'b0001 << lane_q;
            2'd1:    strb_mask = 4'b0011 << lane_q;
            default: strb_mask = 4'b1111;
        endcase

        case (lane_q)
            2'd0:    sel_byte = bus_rdata[7:0];
            2'd1:    sel_byte = bus_rdata[15:8];
            2'd2:    sel_byte = bus_rdata[23:16];
            default: sel_byte = bus_rdata[31:24];
        endcase
        sel_half = lane_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];

        case (size_q)
            2'd0:    load_ext = unsigned_q ? {24'h0, sel_byte}
                                           : {{24{sel_byte[7]}}, sel_byte};
            2'd1:    load_ext = unsigned_q ? {16'h0, sel_half}
                                           : {{16{sel_half[15]}}, sel_half};
            default: load_ext = bus_rdata;
        endcase
    end

    // Next-state and output logic for the request/bus/response sequence.
    always_comb begin
        state_d     = state_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        rdata_d     = rdata_q;
        lane_d      = lane_q;
        size_d      = size_q;
        cause_d     = cause_q;
        unsigned_d  = unsigned_q;
        req_ready   = (state_q == IDLE);
        bus_wstrb   = 4'b0000;
        bus_read_en = 1'b0;
        resp_valid  = 1'b0;
        resp_rdata  = 32'h0;
        resp_cause  = 2'd0;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    bus_addr_d = {req_addr[31:2], 2'b00};
                    lane_d     = req_addr[1:0];
                    size_d     = req_size;
                    unsigned_d = req_unsigned;
                    rdata_d    = 32'h0;
                    cause_d    = CAUSE_OK;
                    if (req_size == 2'd3) begin
                        cause_d = CAUSE_SIZE;
                        state_d = RESP;
                    end else if (req_misaligned) begin
                        cause_d = CAUSE_MISALIGN;
                        state_d = RESP;
                    end else if (req_we) begin
                        case (req_size)
                            2'd0:    bus_wdata_d = {4{req_wdata[7:0]}};
                            2'd1:    bus_wdata_d = {2{req_wdata[15:0]}};
                            default: bus_wdata_d = req_wdata;
                        endcase
                        state_d = WRITE;
                    end else begin
                        state_d = READ;
                    end
                end
            end
            WRITE: begin
                bus_wstrb = strb_mask;
                if (FAULT_EN && !bus_addr_valid) begin
                    bus_wstrb = 4'b0000;
                    cause_d   = CAUSE_ACCESS;
                end
                state_d = RESP;
            end
            READ: begin
                bus_read_en = 1'b1;
                if (FAULT_EN && !bus_addr_valid) begin
                    bus_read_en = 1'b0;
                    cause_d     = CAUSE_ACCESS;
                end
                state_d = CAPTURE;
            end
            CAPTURE: begin
                if (cause_q == CAUSE_OK) begin
                    rdata_d = load_ext;
                end
                state_d = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                resp_rdata = rdata_q;
                resp_cause = cause_q;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and request registers; reset drops any in-flight strobe at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            bus_addr_q  <= 32'h0;
            bus_wdata_q <= 32'h0;
            rdata_q     <= 32'h0;
            lane_q      <= 2'd0;
            size_q      <= 2'd0;
            cause_q     <= 2'd0;
            unsigned_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            rdata_q     <= rdata_d;
            lane_q      <= lane_d;
            size_q      <= size_d;
            cause_q     <= cause_d;
            unsigned_q  <= unsigned_d;
        end
    end

endmodule

// File: tb/tb_mmio_lsu.sv
// tb_mmio_lsu: directed table plus randomized transactions for mmio_lsu,
// with a CLINT-like word responder and a byte-level reference model.

module tb_mmio_lsu;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic [1:0]  req_size = 2'd0;
    logic        req_unsigned = 1'b0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic [1:0]  resp_cause;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_wstrb;
    logic        bus_read_en;
    logic [31:0] bus_rdata = 32'h0;
    logic        bus_addr_valid;

    int n_checks = 0;
    int n_miscompares = 0;

`ifdef MMIO_FAULT_EN
    localparam logic [1:0] UNMAPPED_CAUSE = 2'd2;
    localparam bit FAULT_BUILD = 1'b1;
`else
    localparam logic [1:0] UNMAPPED_CAUSE = 2'd0;
    localparam bit FAULT_BUILD = 1'b0;
`endif

    mmio_lsu dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
        .req_unsigned(req_unsigned),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_cause(resp_cause),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
        .bus_read_en(bus_read_en), .bus_rdata(bus_rdata),
        .bus_addr_valid(bus_addr_valid)
    );

    always #5 clk = ~clk;

    // Responder map: 0x0200_xxxx except the 0x0200_1xxx hole.
    function automatic logic decodeValid(input logic [31:0] a);
        return (a[31:16] == 16'h0200) && (a[15:12] != 4'h1);
    endfunction

    assign bus_addr_valid = decodeValid(bus_addr);

    // Responder: commits strobed bytes on the edge, returns read data next cycle.
    bit [31:0] mem [16384];
    always @(posedge clk) begin
        if (bus_wstrb != 4'b0000 && decodeValid(bus_addr)) begin
            for (int b = 0; b < 4; b++)
                if (bus_wstrb[b]) mem[bus_addr[15:2]][8*b +: 8] <= bus_wdata[8*b +: 8];
        end
        if (bus_read_en)
            bus_rdata <= decodeValid(bus_addr) ? mem[bus_addr[15:2]] : 32'hDEADBEEF;
    end

    // Reference model: byte-addressed memory image of what should be stored.
    logic [7:0] model_mem [logic [31:0]];

    function automatic logic [7:0] modelByte(input logic [31:0] a);
        logic [31:0] junk;
        junk = 32'hDEADBEEF;
        if (!decodeValid(a)) return junk[8*a[1:0] +: 8];
        if (model_mem.exists(a)) return model_mem[a];
        return 8'h00;
    endfunction

    function automatic int sizeBytes(input logic [1:0] size);
        return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    endfunction

    task automatic modelResp(input logic we, input logic [31:0] addr,
                             input logic [1:0] size, input logic uns,
                             output logic [1:0] cause, output logic [31:0] rdata);
        int n;
        n = sizeBytes(size);
        rdata = 32'h0;
        if (size == 2'd3) cause = 2'd3;
        else if ((addr % n) != 0) cause = 2'd1;
        else if (FAULT_BUILD && !decodeValid(addr)) cause = 2'd2;
        else cause = 2'd0;
        if (!we && cause == 2'd0) begin
            for (int b = 0; b < n; b++) rdata = rdata | (32'(modelByte(addr + 32'(b))) << (8*b));
            if (!uns && n < 4 && rdata[8*n-1]) rdata = rdata | ~((32'h1 << (8*n)) - 32'h1);
        end
    endtask

    task automatic modelCommit(input logic we, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [1:0] size,
                               input logic [1:0] cause);
        if (we && cause == 2'd0 && decodeValid(addr))
            for (int b = 0; b < sizeBytes(size); b++)
                model_mem[addr + 32'(b)] = wdata[8*b +: 8];
    endtask

    task automatic checkOutput(input string name, input logic [31:0] got,
                               input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
        end
    endtask

    // Drives one request, watches the bus and response, and checks all of it.
    task automatic applyStimulus(input string tag, input logic we,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [1:0] size, input logic uns,
                                 input logic [1:0] exp_cause, input logic [31:0] exp_rdata);
        int lat, n_wstrb, n_rd, exp_lat, n;
        logic [3:0]  seen_strb, exp_strb;
        logic [31:0] seen_wdata, seen_baddr, got_rdata, exp_wdata, resp_baddr;
        logic [1:0]  got_cause;
        logic        leak;
        bit          go_bus;

        n = sizeBytes(size);
        go_bus = (exp_cause == 2'd0);
        exp_lat = (exp_cause == 2'd1 || exp_cause == 2'd3) ? 1 : (we ? 2 : 3);
        exp_strb = 4'b0000;
        for (int b = 0; b < n; b++) exp_strb[2'(addr[1:0] + 2'(b))] = 1'b1;
        exp_wdata = (size == 2'd0) ? {4{wdata[7:0]}} :
                    (size == 2'd1) ? {2{wdata[15:0]}} : wdata;

        lat = 0; n_wstrb = 0; n_rd = 0; leak = 1'b0;
        seen_strb = 4'h0; seen_wdata = 32'h0; seen_baddr = 32'h0;
        got_rdata = 32'h0; got_cause = 2'd0; resp_baddr = 32'h0;

        @(negedge clk);
        checkOutput({tag, "_ready"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
        req_size = size; req_unsigned = uns;
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_we = 1'($urandom_range(0, 1)); req_addr = $urandom;
        req_wdata = $urandom; req_size = 2'($urandom_range(0, 3));
        req_unsigned = 1'($urandom_range(0, 1));

        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (bus_wstrb != 4'b0000) begin
                n_wstrb++; seen_strb = bus_wstrb; seen_wdata = bus_wdata; seen_baddr = bus_addr;
            end
            if (bus_read_en) n_rd++;
            if (resp_valid) begin
                lat = k; got_rdata = resp_rdata; got_cause = resp_cause; resp_baddr = bus_addr;
                break;
            end
            if (resp_rdata != 32'h0 || resp_cause != 2'd0) leak = 1'b1;
        end

        if (lat == 0) begin
            checkOutput({tag, "_timeout"}, 32'(lat), 32'(exp_lat));
        end else begin
            checkOutput({tag, "_latency"}, 32'(lat), 32'(exp_lat));
            checkOutput({tag, "_cause"}, 32'(got_cause), 32'(exp_cause));
            checkOutput({tag, "_rdata"}, got_rdata, exp_rdata);
            checkOutput({tag, "_busaddr"}, resp_baddr, {addr[31:2], 2'b00});
            checkOutput({tag, "_idle_resp_zero"}, 32'(leak), 32'd0);
            checkOutput({tag, "_wstrb_cycles"}, 32'(n_wstrb), (we && go_bus) ? 32'd1 : 32'd0);
            checkOutput({tag, "_read_en_cycles"}, 32'(n_rd), (!we && go_bus) ? 32'd1 : 32'd0);
            if (we && go_bus) begin
                checkOutput({tag, "_wstrb"}, 32'(seen_strb), 32'(exp_strb));
                checkOutput({tag, "_wdata"}, seen_wdata, exp_wdata);
                checkOutput({tag, "_strobe_addr"}, seen_baddr, {addr[31:2], 2'b00});
            end
        end
    endtask

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  size;
        logic        uns;
        logic [1:0]  cause;
        logic [31:0] rdata;
    } vec_t;

    initial begin
        vec_t        tbl [12];
        logic [1:0]  m_cause;
        logic [31:0] m_rdata, r_addr, r_wdata;
        logic [1:0]  r_size;
        logic        r_we, r_uns;

        tbl[0]  = '{1'b1, 32'h02004000, 32'h00000010, 2'd2, 1'b0, 2'd0, 32'h00000000};
        tbl[1]  = '{1'b0, 32'h02004000, 32'h0,        2'd2, 1'b0, 2'd0, 32'h00000010};
        tbl[2]  = '{1'b1, 32'h02004002, 32'h000000A5, 2'd0, 1'b0, 2'd0, 32'h00000000};
        tbl[3]  = '{1'b0, 32'h02004002, 32'h0,        2'd0, 1'b0, 2'd0, 32'hFFFFFFA5};
        tbl[4]  = '{1'b0, 32'h02004002, 32'h0,        2'd0, 1'b1, 2'd0, 32'h000000A5};
        tbl[5]  = '{1'b1, 32'h02004000, 32'h80017FFF, 2'd2, 1'b0, 2'd0, 32'h00000000};
        tbl[6]  = '{1'b0, 32'h02004002, 32'h0,        2'd1, 1'b0, 2'd0, 32'hFFFF8001};
        tbl[7]  = '{1'b0, 32'h02004002, 32'h0,        2'd1, 1'b1, 2'd0, 32'h00008001};
        tbl[8]  = '{1'b0, 32'h0200BFF9, 32'h0,        2'd2, 1'b0, 2'd1, 32'h00000000};
        tbl[9]  = '{1'b1, 32'h02004000, 32'h12345678, 2'd3, 1'b0, 2'd3, 32'h00000000};
        tbl[10] = '{1'b1, 32'h02001000, 32'hCAFEF00D, 2'd2, 1'b0, UNMAPPED_CAUSE, 32'h0};
        tbl[11] = '{1'b0, 32'h02004000, 32'h0,        2'd2, 1'b0, 2'd0, 32'h80017FFF};

        // Reset state.
        #2;
        checkOutput("reset_req_ready", 32'(req_ready), 32'd1);
        checkOutput("reset_resp_valid", 32'(resp_valid), 32'd0);
        checkOutput("reset_bus_addr", bus_addr, 32'h0);
        checkOutput("reset_bus_wdata", bus_wdata, 32'h0);
        checkOutput("reset_strobes", {27'h0, bus_read_en, bus_wstrb}, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Directed vectors.
        for (int i = 0; i < 12; i++) begin
            applyStimulus($sformatf("vec%0d", i), tbl[i].we, tbl[i].addr, tbl[i].wdata,
                          tbl[i].size, tbl[i].uns, tbl[i].cause, tbl[i].rdata);
            modelCommit(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].size, tbl[i].cause);
        end

        // Reset during the WRITE cycle of a store.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h02004010;
        req_wdata = 32'h12345678; req_size = 2'd2; req_unsigned = 1'b0;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        checkOutput("rst_pre_wstrb", 32'(bus_wstrb), 32'hF);
        #1 rst = 1'b1;
        #1;
        checkOutput("rst_wstrb_drop", 32'(bus_wstrb), 32'h0);
        checkOutput("rst_ready", 32'(req_ready), 32'd1);
        checkOutput("rst_bus_addr", bus_addr, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checkOutput("rst_after_ready", 32'(req_ready), 32'd1);
            checkOutput("rst_after_resp", 32'(resp_valid), 32'd0);
        end
        modelResp(1'b0, 32'h02004010, 2'd2, 1'b0, m_cause, m_rdata);
        applyStimulus("rst_readback", 1'b0, 32'h02004010, 32'h0, 2'd2, 1'b0, m_cause, m_rdata);

        // Randomized transactions against the reference model.
        for (int i = 0; i < 150; i++) begin
            r_we = 1'($urandom_range(0, 1));
            r_uns = 1'($urandom_range(0, 1));
            r_size = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            r_addr = ($urandom_range(0, 7) == 0) ? 32'h02001000 + 32'($urandom_range(0, 15))
                                                 : 32'h02004000 + 32'($urandom_range(0, 31));
            r_wdata = $urandom;
            modelResp(r_we, r_addr, r_size, r_uns, m_cause, m_rdata);
            applyStimulus($sformatf("rand%0d", i), r_we, r_addr, r_wdata, r_size, r_uns,
                          m_cause, m_rdata);
            modelCommit(r_we, r_addr, r_wdata, r_size, m_cause);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_miscompares);
        $finish;
    end

endmodule

// File: doc/mmio_lsu.md
# mmio_lsu

Load/store initiator for the peripheral MMIO bus: the master side of the bus that the CLINT and other memory-mapped peripherals respond on. It accepts one CPU load or store at a time, in byte, halfword or word size, and performs alignment checks. It then drives the responder handshake (`addr` / `wdata` / `wstrb` / `read_en` in, `rdata` / `addr_valid` back), lane-extracts and extends read data, and reports completion or a fault to the CPU memory stage.

## Interface
Parameters:
- `TIMEOUT_UNUSED`, 0, reserved; must be 0. There is no bus timeout, because the responder is fixed-latency.

Ports:
- `clk`  in  1  system clock; rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  CPU request present.
- `req_ready`  out  1  high only in IDLE; a request is accepted when `req_valid && req_ready`.
- `req_we`  in  1  1 = store, 0 = load.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data, right-aligned.
- `req_size`  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal.
- `req_unsigned`  in  1  zero-extend the load (LBU/LHU).
- `resp_valid`  out  1  one-cycle completion pulse.
- `resp_rdata`  out  32  extended load data; 0 for stores and faults.
- `resp_cause`  out  2  0 = ok, 1 = misaligned, 2 = access fault, 3 = illegal size.
- `bus_addr`  out  32  word address to the responder; bits [1:0] are always 0.
- `bus_wdata`  out  32  lane-replicated store data.
- `bus_wstrb`  out  4  byte write strobes; the responder commits on the rising edge at which the strobes are nonzero.
- `bus_read_en`  out  1  read strobe; the responder returns `bus_rdata` in the following cycle.
- `bus_rdata`  in  32  read data from the responder.
- `bus_addr_valid`  in  1  combinational decode of `bus_addr` by the responder.

## Operation
States: IDLE, WRITE, READ, CAPTURE, RESP.

- **IDLE.** On accept, latch the request.
  - Size 3 goes to RESP with cause 3.
  - Misaligned goes to RESP with cause 1. Misaligned means a half with `addr[0]`=1, or a word with `addr[1:0]`≠0.
  - Otherwise go to WRITE (store) or READ (load).
- **WRITE.** One cycle. Drive `bus_wstrb`:
  - byte: `4'b0001 << addr[1:0]`
  - half: `4'b0011 << addr[1:0]`
  - word: `4'b1111`

  `bus_wdata` is `{4{b}}` for a byte, `{2{h}}` for a half, and the word unchanged for a word. Then go to RESP.
- **READ.** One cycle with `bus_read_en`=1, then go to CAPTURE.
- **CAPTURE.** Sample `bus_rdata`. Select the byte or half at `addr[1:0]`, then sign- or zero-extend per `req_unsigned`. Word loads pass through unchanged. Go to RESP.
- **RESP.** `resp_valid`=1 for one cycle, then return to IDLE.

Bus outputs:
- `bus_addr` = `{addr[31:2],2'b00}` from accept onward. `bus_addr` and `bus_wdata` hold their last values when idle.
- `bus_wstrb`=0 and `bus_read_en`=0 outside WRITE and READ.
- Faulting requests (cause 1 or 3) never produce a bus strobe.

## Timing
- Reset, async on any cycle, including mid-transaction:
  - state goes to IDLE;
  - all outputs go to 0, except `req_ready`, which is 1;
  - any in-flight strobe is dropped on the same edge.
- Store latency: accept at edge T, WRITE strobe in cycle T+1, `resp_valid` in cycle T+2.
- Load latency: accept at T, `read_en` in T+1, capture in T+2, `resp_valid` in T+3.
- Fault latency: `resp_valid` in T+1.
- Back-to-back throughput:
  - store: one per 3 cycles;
  - load: one per 4 cycles;
  - fault: one per 2 cycles.
- `req_*` inputs are ignored while `req_ready`=0. They are not required to be held after accept.
- `resp_rdata` and `resp_cause` are valid only while `resp_valid`=1, and are 0 otherwise.

## Configuration
- `MMIO_FAULT_EN` defined:
  - `bus_addr_valid` is sampled in WRITE and in READ.
  - If it is low, `bus_wstrb` is gated to 0 in WRITE (no commit) and `bus_read_en` is gated to 0 in READ.
  - The response carries cause 2 with `resp_rdata`=0. Latency is unchanged.
- `MMIO_FAULT_EN` undefined:
  - `bus_addr_valid` is ignored.
  - Strobes are always driven. Loads return whatever `bus_rdata` holds.
  - Cause 2 is never reported.

## Test plan
- Word store of 0x00000010 to 0x02004000, then word load from 0x02004000 (CLINT-model responder): store `resp_valid` at T+2 with cause 0; load `resp_rdata`=0x00000010 at T+3; `bus_wstrb`=4'b1111 for exactly one cycle.
- Byte store of 0x000000A5 to 0x02004002, then LB and LBU from the same address: `bus_wstrb`=4'b0100 and `bus_wdata`=0xA5A5A5A5; LB returns 0xFFFFFFA5; LBU returns 0x000000A5.
- Half load from 0x02004002 with the word at 0x02004000 = 0x8001_7FFF: LH returns 0xFFFF8001; LHU returns 0x00008001.
- Misaligned word load from 0x0200BFF9, and a request with size 3: each gives `resp_valid` at T+1 with cause 1 or 3 respectively; `bus_read_en` and `bus_wstrb` never assert.
- With `MMIO_FAULT_EN`, a word store to 0x02001000: cause 2, `bus_wstrb` stays 0, and a later read of 0x02004000 is unchanged. Without the macro, the same store reports cause 0.
- Assert `rst` during the WRITE cycle of a store: the strobe drops immediately and the responder register is unchanged; after release, `req_ready`=1 and `resp_valid`=0 until a new request.
